// File: rtl/ss_pkg.sv
// ss_pkg
// Shared definitions for the universal shift register and the wrapper that
// drives it: the 3-bit operation encodings and the mode type.
//
// Ports: none (package).
package ss_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_SHR   = 3'b001;
  localparam mode_t MODE_SHL   = 3'b010;
  localparam mode_t MODE_LOAD  = 3'b011;
  localparam mode_t MODE_ROR   = 3'b100;
  localparam mode_t MODE_ROL   = 3'b101;
  localparam mode_t MODE_CLEAR = 3'b110;
  // 3'b111 is reserved and decodes as HOLD.

endpackage

// File: rtl/ss_shift_counter.sv
// ss_shift_counter
// Counts shift/rotate operations and pulses word_done on the operation that
// completes a full WIDTH-bit word, wrapping the count back to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         clock enable; when low the count holds and word_done is 0
//   inc        one shift/rotate operation this cycle
//   clr        discard the partial count (load or clear); wins over inc
//   shift_cnt  operations since the last clear/reset, 0..WIDTH-1
//   word_done  one-cycle pulse on the edge that completes a word
module ss_shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // word_done defaults low every edge so it can only ever be a single-cycle
  // pulse; reaching WIDTH is never stored, the count wraps straight to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        if (clr) begin
          shift_cnt <= '0;
        end else if (inc) begin
          if (shift_cnt == LAST) begin
            shift_cnt <= '0;
            word_done <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ss_univ_shift_reg.sv
// ss_univ_shift_reg
// Parametrised universal shift register: shift right/left with serial input,
// parallel load, clear, optional rotate, and a word-completion counter.
// Rotate modes are built only when the macro SS_ROTATE_EN is defined;
// otherwise ROR/ROL decode as HOLD and no rotate logic exists.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         clock enable; when low all state holds
//   mode       operation select (see ss_pkg)
//   ser_in     serial data input
//   par_in     parallel load data
//   q          register contents
//   ser_out    bit most recently shifted or rotated out
//   shift_cnt  shift operations since last load, clear or reset
//   word_done  one-cycle pulse when WIDTH operations complete
module ss_univ_shift_reg
  import ss_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  mode_t            mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] q_next;
  logic             ser_out_next;
  logic             inc;
  logic             clr;

  // Next-state decode for the datapath plus the counter's inc/clr requests.
  // Reserved and (when rotate is disabled) rotate encodings fall through to
  // the defaults, i.e. HOLD.
  always_comb begin
    q_next       = q;
    ser_out_next = ser_out;
    inc          = 1'b0;
    clr          = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_next       = {ser_in, q[WIDTH-1:1]};
        ser_out_next = q[0];
        inc          = 1'b1;
      end
      MODE_SHL: begin
        q_next       = {q[WIDTH-2:0], ser_in};
        ser_out_next = q[WIDTH-1];
        inc          = 1'b1;
      end
      MODE_LOAD: begin
        q_next = par_in;
        clr    = 1'b1;
      end
`ifdef SS_ROTATE_EN
      MODE_ROR: begin
        q_next       = {q[0], q[WIDTH-1:1]};
        ser_out_next = q[0];
        inc          = 1'b1;
      end
      MODE_ROL: begin
        q_next       = {q[WIDTH-2:0], q[WIDTH-1]};
        ser_out_next = q[WIDTH-1];
        inc          = 1'b1;
      end
`endif
      MODE_CLEAR: begin
        q_next       = '0;
        ser_out_next = 1'b0;
        clr          = 1'b1;
      end
      default: begin
        q_next       = q;
        ser_out_next = ser_out;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      ser_out <= 1'b0;
    end else if (en) begin
      q       <= q_next;
      ser_out <= ser_out_next;
    end
  end

  ss_shift_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .inc      (inc),
    .clr      (clr),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );

endmodule

// File: tb/tb_ss_univ_shift_reg.sv
// tb_ss_univ_shift_reg
// Self-checking bench for ss_univ_shift_reg at WIDTH=8: directed scenarios
// followed by random operations, all compared against an arithmetic model.
module tb_ss_univ_shift_reg;

  localparam int W    = 8;
  localparam int CW   = $clog2(W + 1);
  localparam int FULL = 2 ** W;
  localparam int MSBV = 2 ** (W - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic          ser_in = 1'b0;
  logic [W-1:0]  par_in = '0;
  logic [W-1:0]  q;
  logic          ser_out;
  logic [CW-1:0] shift_cnt;
  logic          word_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the register value as a plain integer.
  int m_q = 0;
  int m_so = 0;
  int m_cnt = 0;
  int m_done = 0;

  ss_univ_shift_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .ser_in   (ser_in),
    .par_in   (par_in),
    .q        (q),
    .ser_out  (ser_out),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  // Generic comparison point.
  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".q"},         int'(q),         m_q);
    checkVal({tag, ".ser_out"},   int'(ser_out),   m_so);
    checkVal({tag, ".shift_cnt"}, int'(shift_cnt), m_cnt);
    checkVal({tag, ".word_done"}, int'(word_done), m_done);
  endtask

  function automatic void countOp();
    m_cnt++;
    if (m_cnt == W) begin
      m_cnt  = 0;
      m_done = 1;
    end
  endfunction

  // Advance the model by one clock edge using the values about to be applied.
  function automatic void modelStep(input bit r, input bit e, input int m,
                                    input bit s, input int p);
    bit rot;
`ifdef SS_ROTATE_EN
    rot = 1'b1;
`else
    rot = 1'b0;
`endif
    if (!r) begin
      m_q = 0; m_so = 0; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!e) return;
    case (m)
      1: begin m_so = m_q % 2; m_q = m_q / 2 + (s ? MSBV : 0); countOp(); end
      2: begin m_so = m_q / MSBV; m_q = (m_q * 2) % FULL + int'(s); countOp(); end
      3: begin m_q = p; m_cnt = 0; end
      4: if (rot) begin m_so = m_q % 2; m_q = m_q / 2 + m_so * MSBV; countOp(); end
      5: if (rot) begin m_so = m_q / MSBV; m_q = (m_q * 2) % FULL + m_so; countOp(); end
      6: begin m_q = 0; m_so = 0; m_cnt = 0; end
      default: ;
    endcase
  endfunction

  // Drive one cycle, let the edge happen, then compare everything.
  task automatic applyStimulus(input bit r, input bit e, input int m,
                               input bit s, input int p, input string tag);
    rst_n  = r;
    en     = e;
    mode   = 3'(m);
    ser_in = s;
    par_in = W'(p);
    modelStep(r, e, m, s, p);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit sr_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int exp_so[3]  = '{1, 0, 1};
    int pulses;

    #1;
    // Reset wins over en/LOAD.
    applyStimulus(0, 1, 3, 0, 'hFF, "reset0");
    applyStimulus(0, 1, 3, 0, 'hFF, "reset1");
    checkVal("reset.q", int'(q), 0);
    checkVal("reset.word_done", int'(word_done), 0);

    // Serial right: eight bits in, pulse on the 8th edge only.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 1, sr_bits[i], 0, "shr");
      checkVal("shr.pulse", int'(word_done), (i == 7) ? 1 : 0);
    end
    checkVal("shr.q", int'(q), 'h4D);
    checkVal("shr.cnt", int'(shift_cnt), 0);

    // Load then left shift.
    applyStimulus(1, 1, 3, 0, 'hA5, "load");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 2, 0, 0, "shl");
      checkVal("shl.ser_out", int'(ser_out), exp_so[i]);
    end
    checkVal("shl.q", int'(q), 'h28);
    checkVal("shl.cnt", int'(shift_cnt), 3);

    // Enable gating.
    applyStimulus(1, 1, 3, 0, 'h81, "gload");
    applyStimulus(1, 1, 1, 0, 0, "gshr");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 1, 1, 0, "gstall");
      checkVal("gstall.pulse", int'(word_done), 0);
    end
    applyStimulus(1, 1, 1, 0, 0, "gshr2");
    checkVal("gate.q", int'(q), 'h20);
    checkVal("gate.cnt", int'(shift_cnt), 2);

    // Rotate left a full word.
    applyStimulus(1, 1, 3, 0, 'h81, "rload");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 5, 1, 0, "rol");
      pulses += int'(word_done);
    end
    checkVal("rol.q", int'(q), 'h81);
`ifdef SS_ROTATE_EN
    checkVal("rol.last_pulse", int'(word_done), 1);
    checkVal("rol.pulses", pulses, 1);
`else
    checkVal("rol.cnt", int'(shift_cnt), 0);
    checkVal("rol.pulses", pulses, 0);
`endif

    // Mid-word CLEAR, then mid-word reset: partial count discarded.
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(1, 1, 3, 0, 'h3C, "mload");
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, 2, 1, 0, "mshl");
      if (pass == 0) applyStimulus(1, 1, 6, 0, 0, "mclear");
      else           applyStimulus(0, 1, 2, 1, 0, "mreset");
      checkVal("mid.cnt0", int'(shift_cnt), 0);
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1, 1, 2, 1, 0, "mshl2");
        checkVal("mid.pulse", int'(word_done), (i == 7) ? 1 : 0);
      end
    end

    // Random operations against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(39) != 0), ($urandom_range(3) != 0),
                    int'($urandom_range(7)), 1'($urandom_range(1)),
                    int'($urandom_range(FULL - 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_univ_shift_reg.md
# ss_univ_shift_reg

Parametrised universal shift register: the next generation of the serial-in/serial-out, left/right shift register used behind the TinyTapeout top wrapper. It adds:
- configurable width
- parallel load and clear
- optional rotate modes
- a shift counter that pulses after every complete word has been shifted

It is intended to replace the fixed 8-bit serial register as the datapath core instantiated by the top-level wrapper.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  clock enable; when low, all state holds.
- mode  in  3  operation select (see Operation).
- ser_in  in  1  serial data input.
- par_in  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit most recently shifted or rotated out.
- shift_cnt  out  CNT_W  shift operations since the last load, clear or reset.
- word_done  out  1  one-cycle pulse when shift_cnt completes WIDTH operations.

## Operation

Mode encoding, evaluated only when en=1:
- 000 HOLD: no change.
- 001 SHR: q <= {ser_in, q[WIDTH-1:1]}; ser_out <= q[0].
- 010 SHL: q <= {q[WIDTH-2:0], ser_in}; ser_out <= q[WIDTH-1].
- 011 LOAD: q <= par_in; shift_cnt <= 0; ser_out unchanged.
- 100 ROR: q <= {q[0], q[WIDTH-1:1]}; ser_out <= q[0]; ser_in ignored.
- 101 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ser_out <= q[WIDTH-1]; ser_in ignored.
- 110 CLEAR: q <= 0; ser_out <= 0; shift_cnt <= 0.
- 111 reserved; behaves as HOLD.

Shift counter:
- Increments on SHR, SHL, ROR and ROL.
- Unaffected by HOLD.
- Set to 0 by LOAD and CLEAR.
- Wraps: an op taking the count to WIDTH instead sets shift_cnt <= 0 and word_done <= 1 in the same edge.
- word_done is 0 on every other edge, including edges with en=0.
- Direction changes mid-word do not reset the counter.

Priority:
- rst_n=0 takes precedence over en and mode.
- After reset: q=0, ser_out=0, shift_cnt=0, word_done=0.
- Reset asserted mid-word discards the partial count; no word_done is produced.

## Timing

- All outputs are registered and update only on the rising edge of clk; there are no combinational input-to-output paths.
- Latency is 1 cycle: the effect of mode/ser_in/par_in sampled at edge N is visible on q, ser_out, shift_cnt and word_done after edge N.
- ser_in is sampled at the same edge as the shift that consumes it.
- A serial word crosses the register in WIDTH enabled shift cycles. With the same direction throughout, the first bit entered appears on ser_out after WIDTH+1 enabled shift edges.
- en may toggle freely; disabled cycles are invisible to the count.

## Configuration

- Macro: SS_ROTATE_EN.
- Defined: modes 100 (ROR) and 101 (ROL) operate as specified and count toward word_done.
- Undefined: modes 100 and 101 behave as HOLD: q, ser_out and shift_cnt are unchanged and word_done stays 0. The rotate datapath must not be synthesised.

## Structure

- Shared package ss_pkg holds:
  - the 3-bit mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_CLEAR;
  - the mode typedef.
- The top-level wrapper imports the same package to drive mode from ui_in.
- One sub-module, ss_shift_counter, is natural. It is parametrised by WIDTH and contains:
  - inputs: clk, rst_n, en, inc, clr;
  - outputs: shift_cnt, word_done;
  - the wrap logic.
- The shift/rotate/load datapath stays in ss_univ_shift_reg.

## Test plan

All scenarios use WIDTH=8.
- Reset: drive rst_n=0 for 2 cycles with en=1, mode=LOAD, par_in=8'hFF -> q=8'h00, ser_out=0, shift_cnt=0, word_done=0.
- Serial right: 8× SHR with ser_in = 1,0,1,1,0,0,1,0 -> q=8'h4D; word_done pulses exactly on the 8th edge; shift_cnt returns to 0.
- Load then left shift: LOAD 8'hA5, then 3× SHL with ser_in=0 -> q=8'h28, ser_out sequence 1,0,1; shift_cnt=3.
- Enable gating: LOAD 8'h81; SHR; en=0 for 5 cycles with mode=SHR; SHR -> q=8'h20; shift_cnt=2; no word_done during the stall.
- Rotate (SS_ROTATE_EN defined): LOAD 8'h81; 8× ROL -> q=8'h81; word_done on the 8th edge. Same stimulus with the macro undefined -> q stays 8'h81, shift_cnt=0, word_done never asserts.
- Mid-word clear and reset: 5× SHL, CLEAR, 8× SHL -> word_done only on the 13th op edge overall, not the 8th. Repeating with rst_n low for one cycle in place of CLEAR gives the same counter result.
